// File: rtl/float_pkg.sv
// Shared floating-point helpers for the multiplier and the adder.
// Holds format widths, flag bit positions and bias/emax helpers.
package float_pkg;
    // Default 12-bit operand format {sign, exp[4:0], man[5:0]}
    localparam int F12_EXP_W = 5;
    localparam int F12_MAN_W = 6;
    localparam int F12_DW    = 1 + F12_EXP_W + F12_MAN_W;

    // Exception flag bit positions inside flags_t
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_ZERO = 0;
    localparam int FLAGS_W   = 3;

    typedef logic [FLAGS_W-1:0] flags_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int emax(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction
endpackage

// File: rtl/float_mult_param_if.sv
// Operand/result handshake bundle for float_mult_param.
//   slave  : the multiplier (takes operands, produces result)
//   master : the upstream/downstream side driving operands and ready_i
interface float_mult_param_if
    import float_pkg::*;
#(
    parameter int EXP_W = F12_EXP_W,
    parameter int MAN_W = F12_MAN_W
);
    localparam int DW = 1 + EXP_W + MAN_W;

    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_1_i;
    logic [DW-1:0] data_2_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_mult_o;
    flags_t        flags_o;

    modport slave (
        input  valid_i, data_1_i, data_2_i, ready_i,
        output ready_o, valid_o, data_mult_o, flags_o
    );

    modport master (
        output valid_i, data_1_i, data_2_i, ready_i,
        input  ready_o, valid_o, data_mult_o, flags_o
    );
endinterface

// File: rtl/float_round_norm.sv
// Normalise / round / saturate back end (pipeline stages 2 and 3).
//   clk_i, rst_n_i : clock, async active-low reset
//   en_i           : stage-2 load (global pipeline advance)
//   ld_i           : stage-3 load (advance with a valid item entering)
//   sign_i, esum_i, prod_i, zin_i : raw stage-1 results
//   data_o, flags_o: packed result and {ovf, unf, zero}
module float_round_norm
    import float_pkg::*;
#(
    parameter int EXP_W    = F12_EXP_W,
    parameter int MAN_W    = F12_MAN_W,
    parameter int ROUND_EN = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic                   ld_i,
    input  logic                   sign_i,
    input  logic [EXP_W+1:0]       esum_i,
    input  logic [2*MAN_W+1:0]     prod_i,
    input  logic                   zin_i,
    output logic [EXP_W+MAN_W:0]   data_o,
    output flags_t                 flags_o
);
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS_S = EW'(bias(EXP_W));
    localparam logic signed [EW-1:0] EMAX_S = EW'(emax(EXP_W));

    // ---- stage 2: de-bias and normalise ----
    logic signed [EW-1:0] ebias, n_e;
    logic [MAN_W-1:0]     n_man;
    logic                 n_g, n_s;

    always_comb begin
        // esum never exceeds 2*EMAX, so its top bit is 0 and the signed view is exact
        ebias = $signed(esum_i) - BIAS_S;
        n_man = prod_i[PW-3 -: MAN_W];
        n_g   = prod_i[PW-3-MAN_W];
        n_s   = |prod_i[PW-4-MAN_W:0];
        n_e   = ebias;
        if (prod_i[PW-1]) begin
            // product in [2,4): hidden bit sits at the MSB
            n_man = prod_i[PW-2 -: MAN_W];
            n_g   = prod_i[PW-2-MAN_W];
            n_s   = |prod_i[PW-3-MAN_W:0];
            n_e   = ebias + EW'(1);
        end
    end

    logic                 s2_sign, s2_zin, s2_g, s2_s;
    logic signed [EW-1:0] s2_e;
    logic [MAN_W-1:0]     s2_man;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_sign <= 1'b0;
            s2_zin  <= 1'b0;
            s2_g    <= 1'b0;
            s2_s    <= 1'b0;
            s2_e    <= '0;
            s2_man  <= '0;
        end else if (en_i) begin
            s2_sign <= sign_i;
            s2_zin  <= zin_i;
            s2_g    <= n_g;
            s2_s    <= n_s;
            s2_e    <= n_e;
            s2_man  <= n_man;
        end
    end

    // ---- stage 3: round, then classify ----
    logic                 rnd_up;
    logic [MAN_W:0]       man_sum;
    logic signed [EW-1:0] e_r;
    logic [EXP_W+MAN_W:0] res;
    flags_t               fl;

    always_comb begin
        rnd_up  = (ROUND_EN != 0) && s2_g && (s2_s || s2_man[0]);
        man_sum = {1'b0, s2_man} + {{MAN_W{1'b0}}, rnd_up};
        // carry-out leaves the stored mantissa at 0; only the exponent moves
        e_r     = man_sum[MAN_W] ? s2_e + EW'(1) : s2_e;
        res     = '0;
        fl      = '0;
        if (s2_zin) begin
            fl[FLAG_ZERO] = 1'b1;
        end else if (e_r[EW-1] || e_r == '0) begin
            fl[FLAG_UNF]  = 1'b1;
            fl[FLAG_ZERO] = 1'b1;
        end else if (e_r >= EMAX_S) begin
            res          = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            fl[FLAG_OVF] = 1'b1;
        end else begin
            res = {s2_sign, e_r[EXP_W-1:0], man_sum[MAN_W-1:0]};
        end
    end

    // Only real items update the output so it holds across bubbles
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o  <= '0;
            flags_o <= '0;
        end else if (ld_i) begin
            data_o  <= res;
            flags_o <= fl;
        end
    end
endmodule

// File: rtl/float_mult_param.sv
// Pipelined floating-point multiplier, 3 stages, valid/ready handshake.
//   clk_i, rst_n_i : clock, async active-low reset
//   bus (slave)    : valid_i/ready_o + data_1_i/data_2_i operands in,
//                    valid_o/ready_i + data_mult_o/flags_o result out
// The whole pipe advances together; a stalled output freezes every stage.
module float_mult_param
    import float_pkg::*;
#(
    parameter int EXP_W    = F12_EXP_W,
    parameter int MAN_W    = F12_MAN_W,
    parameter int ROUND_EN = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    float_mult_param_if.slave    bus
);
    localparam int STAGES = 3;
    localparam int DW     = 1 + EXP_W + MAN_W;
    localparam int PW     = 2 * MAN_W + 2;

    logic [STAGES:1] vld_pipe;
    logic            en;

    assign en          = ~vld_pipe[STAGES] | bus.ready_i;
    assign bus.ready_o = en;
    assign bus.valid_o = vld_pipe[STAGES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            vld_pipe <= '0;
        else if (en)
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.valid_i};
    end

    // ---- stage 1: sign, exponent sum, mantissa product ----
    logic             a_s, b_s;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_m, b_m;

    assign a_s = bus.data_1_i[DW-1];
    assign b_s = bus.data_2_i[DW-1];
    assign a_e = bus.data_1_i[DW-2 -: EXP_W];
    assign b_e = bus.data_2_i[DW-2 -: EXP_W];
    assign a_m = bus.data_1_i[MAN_W-1:0];
    assign b_m = bus.data_2_i[MAN_W-1:0];

    logic             s1_sign, s1_zin;
    logic [EXP_W+1:0] s1_esum;
    logic [PW-1:0]    s1_prod;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_sign <= 1'b0;
            s1_zin  <= 1'b0;
            s1_esum <= '0;
            s1_prod <= '0;
        end else if (en) begin
            s1_sign <= a_s ^ b_s;
            // exponent 0 encodes zero; denormals are flushed
            s1_zin  <= (a_e == '0) || (b_e == '0);
            s1_esum <= {2'b00, a_e} + {2'b00, b_e};
            s1_prod <= {{(MAN_W+1){1'b0}}, 1'b1, a_m} * {{(MAN_W+1){1'b0}}, 1'b1, b_m};
        end
    end

    float_round_norm #(
        .EXP_W    (EXP_W),
        .MAN_W    (MAN_W),
        .ROUND_EN (ROUND_EN)
    ) u_round_norm (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en),
        .ld_i    (en & vld_pipe[2]),
        .sign_i  (s1_sign),
        .esum_i  (s1_esum),
        .prod_i  (s1_prod),
        .zin_i   (s1_zin),
        .data_o  (bus.data_mult_o),
        .flags_o (bus.flags_o)
    );
endmodule

// File: tb/tb_float_mult_param.sv
// Directed-vector bench for float_mult_param (EXP_W=5, MAN_W=6).
// A second instance with ROUND_EN=0 shares the same stimulus.
module tb_float_mult_param;
    logic clk_i;
    logic rst_n_i;

    float_mult_param_if #(.EXP_W(5), .MAN_W(6)) bus   ();
    float_mult_param_if #(.EXP_W(5), .MAN_W(6)) bus_t ();

    assign bus_t.valid_i  = bus.valid_i;
    assign bus_t.data_1_i = bus.data_1_i;
    assign bus_t.data_2_i = bus.data_2_i;
    assign bus_t.ready_i  = bus.ready_i;

    float_mult_param #(.EXP_W(5), .MAN_W(6), .ROUND_EN(1)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    float_mult_param #(.EXP_W(5), .MAN_W(6), .ROUND_EN(0)) dut_t (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus_t)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // operand A, operand B, RNE result, flags, truncated result
    logic [11:0] va  [8];
    logic [11:0] vb  [8];
    logic [11:0] vd  [8];
    logic [2:0]  vf  [8];
    logic [11:0] vdt [8];

    // Apply one pair on an idle pipe, wait for its result, check latency and value
    task automatic run1(input string tag, input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] ed, input logic [2:0] ef, input logic [11:0] edt);
        int lat;
        @(negedge clk_i);
        bus.valid_i  = 1'b1;
        bus.data_1_i = a;
        bus.data_2_i = b;
        bus.ready_i  = 1'b1;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        lat = 1;
        while (!bus.valid_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        chk({tag, ".lat"},   32'(lat), 32'd3);
        chk({tag, ".data"},  32'(bus.data_mult_o), 32'(ed));
        chk({tag, ".flags"}, 32'(bus.flags_o), 32'(ef));
        chk({tag, ".trunc"}, 32'(bus_t.data_mult_o), 32'(edt));
    endtask

    initial begin
        va[0] = 12'h3C0; vb[0] = 12'h3C0; vd[0] = 12'h3C0; vf[0] = 3'b000; vdt[0] = 12'h3C0;
        va[1] = 12'h3E0; vb[1] = 12'h3E0; vd[1] = 12'h408; vf[1] = 3'b000; vdt[1] = 12'h408;
        va[2] = 12'hC00; vb[2] = 12'h420; vd[2] = 12'hC60; vf[2] = 3'b000; vdt[2] = 12'hC60;
        va[3] = 12'h000; vb[3] = 12'hC60; vd[3] = 12'h000; vf[3] = 3'b001; vdt[3] = 12'h000;
        va[4] = 12'h3E0; vb[4] = 12'h3C1; vd[4] = 12'h3E2; vf[4] = 3'b000; vdt[4] = 12'h3E1;
        va[5] = 12'h7C0; vb[5] = 12'h7C0; vd[5] = 12'h7FF; vf[5] = 3'b100; vdt[5] = 12'h7FF;
        va[6] = 12'h040; vb[6] = 12'h040; vd[6] = 12'h000; vf[6] = 3'b011; vdt[6] = 12'h000;
        va[7] = 12'h420; vb[7] = 12'h420; vd[7] = 12'h488; vf[7] = 3'b000; vdt[7] = 12'h488;

        rst_n_i      = 1'b0;
        bus.valid_i  = 1'b0;
        bus.ready_i  = 1'b1;
        bus.data_1_i = '0;
        bus.data_2_i = '0;
        #1;
        chk("rst.valid_o", 32'(bus.valid_o), 32'd0);
        chk("rst.data",    32'(bus.data_mult_o), 32'd0);
        chk("rst.flags",   32'(bus.flags_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        // single vectors on an idle pipe
        for (int i = 0; i < 8; i++)
            run1($sformatf("vec%0d", i), va[i], vb[i], vd[i], vf[i], vdt[i]);

        // streaming with downstream backpressure 1,0,0,1,0,0,...
        begin
            int tx, rx, cyc;
            tx = 0; rx = 0; cyc = 0;
            while (rx < 8 && cyc < 200) begin
                @(negedge clk_i);
                bus.ready_i = (cyc % 3 == 0);
                #1;
                chk("bp.ready_o", 32'(bus.ready_o), 32'(!(bus.valid_o && !bus.ready_i)));
                if (bus.valid_o && bus.ready_i) begin
                    chk($sformatf("bp.data%0d", rx),  32'(bus.data_mult_o), 32'(vd[rx]));
                    chk($sformatf("bp.flags%0d", rx), 32'(bus.flags_o), 32'(vf[rx]));
                    rx++;
                end
                if (tx < 8) begin
                    bus.valid_i  = 1'b1;
                    bus.data_1_i = va[tx];
                    bus.data_2_i = vb[tx];
                    if (bus.ready_o) tx++;
                end else begin
                    bus.valid_i = 1'b0;
                end
                cyc++;
            end
            if (rx < 8) chk("bp.timeout", 32'(rx), 32'd8);
            bus.ready_i = 1'b1;
            bus.valid_i = 1'b0;
            // nothing extra may emerge once all eight have been taken
            repeat (5) begin
                @(negedge clk_i);
                chk("bp.drain", 32'(bus.valid_o), 32'd0);
            end
        end

        // reset with three items in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            bus.valid_i  = 1'b1;
            bus.data_1_i = va[i + 2];
            bus.data_2_i = vb[i + 2];
        end
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        chk("midrst.pre_valid", 32'(bus.valid_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("midrst.valid_o", 32'(bus.valid_o), 32'd0);
        chk("midrst.data",    32'(bus.data_mult_o), 32'd0);
        chk("midrst.flags",   32'(bus.flags_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        run1("postrst", 12'h3E0, 12'h3E0, 12'h408, 3'b000, 12'h408);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
